// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read ports, two writeback ports, issue/flush control, busy count.
interface regfile_mp_if #(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned NUMREGS   = 32,
  parameter int unsigned NREAD     = 2
);
  localparam int unsigned ADDRW = (NUMREGS > 1) ? $clog2(NUMREGS) : 1;

  logic [NREAD*ADDRW-1:0]     readAddr;
  logic [NREAD*DATAWIDTH-1:0] readData;
  logic [NREAD-1:0]           readBusy;

  logic                       wrEn0;
  logic [ADDRW-1:0]           wrAddr0;
  logic [DATAWIDTH-1:0]       wrData0;

  logic                       wrEn1;
  logic [ADDRW-1:0]           wrAddr1;
  logic [DATAWIDTH-1:0]       wrData1;

  logic                       issueEn;
  logic [ADDRW-1:0]           issueReg;
  logic                       flush;

  logic [ADDRW:0]             busyCount;

  // Issue/writeback side drives requests and observes read results.
  modport master (
    output readAddr, wrEn0, wrAddr0, wrData0, wrEn1, wrAddr1, wrData1,
           issueEn, issueReg, flush,
    input  readData, readBusy, busyCount
  );

  // Register file side.
  modport slave (
    input  readAddr, wrEn0, wrAddr0, wrData0, wrEn1, wrAddr1, wrData1,
           issueEn, issueReg, flush,
    output readData, readBusy, busyCount
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-through bypass and a per-register busy scoreboard.
module regfile_mp #(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned NUMREGS   = 32,
  parameter int unsigned NREAD     = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_mp_if.slave  rf
);
  localparam int unsigned ADDRW = (NUMREGS > 1) ? $clog2(NUMREGS) : 1;
  localparam int unsigned CNTW  = ADDRW + 1;

  logic [DATAWIDTH-1:0] mem_q [NUMREGS];
  logic [DATAWIDTH-1:0] mem_d [NUMREGS];
  logic [NUMREGS-1:0]   busy_q;
  logic [NUMREGS-1:0]   busy_d;
  logic [CNTW-1:0]      busy_count_q;
  logic [CNTW-1:0]      busy_count_d;

  // Array next state: port 1 is applied last so it wins a same-address collision; entry 0 stays zero.
  always_comb begin
    mem_d = mem_q;
    if (rf.wrEn0 && (rf.wrAddr0 != '0)) mem_d[rf.wrAddr0] = rf.wrData0;
    if (rf.wrEn1 && (rf.wrAddr1 != '0)) mem_d[rf.wrAddr1] = rf.wrData1;
    mem_d[0] = '0;
  end

  // Scoreboard next state: flush beats issue, issue beats writeback clear; count tracks the new vector.
  always_comb begin
    busy_d       = busy_q;
    busy_count_d = '0;
    for (int unsigned r = 1; r < NUMREGS; r++) begin
      if (rf.flush) begin
        busy_d[r] = 1'b0;
      end else if (rf.issueEn && (rf.issueReg == ADDRW'(r))) begin
        busy_d[r] = 1'b1;
      end else if ((rf.wrEn0 && (rf.wrAddr0 == ADDRW'(r))) ||
                   (rf.wrEn1 && (rf.wrAddr1 == ADDRW'(r)))) begin
        busy_d[r] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
    for (int unsigned r = 0; r < NUMREGS; r++) begin
      busy_count_d = busy_count_d + CNTW'(busy_d[r]);
    end
  end

  // State registers; reset clears contents, scoreboard and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NUMREGS; r++) begin
        mem_q[r] <= '0;
      end
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      mem_q        <= mem_d;
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  assign rf.busyCount = busy_count_q;

  // Combinational read ports; bypass is suppressed in reset so reads return zero there.
  for (genvar k = 0; k < int'(NREAD); k++) begin : g_rd
    logic [ADDRW-1:0] addr_c;
    logic             hit0_c;
    logic             hit1_c;

    assign addr_c = rf.readAddr[k*ADDRW +: ADDRW];
    assign hit0_c = rst_n && rf.wrEn0 && (rf.wrAddr0 == addr_c);
    assign hit1_c = rst_n && rf.wrEn1 && (rf.wrAddr1 == addr_c);

    assign rf.readData[k*DATAWIDTH +: DATAWIDTH] =
      (addr_c == '0) ? '0 :
      hit1_c         ? rf.wrData1 :
      hit0_c         ? rf.wrData0 :
                       mem_q[addr_c];

    assign rf.readBusy[k] = busy_q[addr_c] && !(hit0_c || hit1_c);
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp: default build and a 16x64, 4-read-port build.
module tb_regfile_mp;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  regfile_mp_if #(.DATAWIDTH(32), .NUMREGS(32), .NREAD(2)) ifa ();
  regfile_mp_if #(.DATAWIDTH(64), .NUMREGS(16), .NREAD(4)) ifb ();

  regfile_mp #(.DATAWIDTH(32), .NUMREGS(32), .NREAD(2)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (ifa)
  );

  regfile_mp #(.DATAWIDTH(64), .NUMREGS(16), .NREAD(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (ifb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [63:0] v;
    clk    = 1'b0;
    errors = 0;
    checks = 0;
    rst_n  = 1'b1;
    ifa.readAddr = '0; ifa.wrEn0 = 1'b0; ifa.wrAddr0 = '0; ifa.wrData0 = '0;
    ifa.wrEn1 = 1'b0; ifa.wrAddr1 = '0; ifa.wrData1 = '0;
    ifa.issueEn = 1'b0; ifa.issueReg = '0; ifa.flush = 1'b0;
    ifb.readAddr = '0; ifb.wrEn0 = 1'b0; ifb.wrAddr0 = '0; ifb.wrData0 = '0;
    ifb.wrEn1 = 1'b0; ifb.wrAddr1 = '0; ifb.wrData1 = '0;
    ifb.issueEn = 1'b0; ifb.issueReg = '0; ifb.flush = 1'b0;

    // Power-on reset
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busycount", 64'(ifa.busyCount), 64'd0);
    chk("rst_readbusy",  64'(ifa.readBusy),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Write R5, issue R6, then reset mid-cycle
    ifa.wrEn0 = 1'b1; ifa.wrAddr0 = 5'd5; ifa.wrData0 = 32'hDEADBEEF;
    ifa.issueEn = 1'b1; ifa.issueReg = 5'd6;
    @(negedge clk);
    ifa.wrEn0 = 1'b0; ifa.issueEn = 1'b0;
    ifa.readAddr = {5'd6, 5'd5};
    #1;
    chk("r5_written",      64'(ifa.readData[31:0]), 64'hDEADBEEF);
    chk("r6_busy_pre_rst", 64'(ifa.readBusy[1]),    64'd1);
    chk("count_pre_rst",   64'(ifa.busyCount),      64'd1);
    ifa.wrEn0 = 1'b1; ifa.wrData0 = 32'h5555AAAA;
    #1 rst_n = 1'b0;
    #1;
    chk("r5_in_rst",        64'(ifa.readData[31:0]), 64'd0);
    chk("count_in_rst",     64'(ifa.busyCount),      64'd0);
    chk("readbusy_in_rst",  64'(ifa.readBusy),       64'd0);
    @(negedge clk);
    ifa.wrEn0 = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("r5_after_rst", 64'(ifa.readData[31:0]), 64'd0);

    // R0 protection
    @(negedge clk);
    ifa.wrEn0 = 1'b1; ifa.wrAddr0 = 5'd0; ifa.wrData0 = 32'h1234;
    ifa.issueEn = 1'b1; ifa.issueReg = 5'd0;
    ifa.readAddr = {5'd0, 5'd0};
    #1;
    chk("r0_same_cycle", 64'(ifa.readData[31:0]), 64'd0);
    @(negedge clk);
    ifa.wrEn0 = 1'b0; ifa.issueEn = 1'b0;
    #1;
    chk("r0_next_cycle", 64'(ifa.readData[31:0]), 64'd0);
    chk("r0_count",      64'(ifa.busyCount),      64'd0);
    chk("r0_readbusy",   64'(ifa.readBusy[0]),    64'd0);

    // Bypass priority: both ports write R7
    @(negedge clk);
    ifa.wrEn0 = 1'b1; ifa.wrAddr0 = 5'd7; ifa.wrData0 = 32'h11;
    ifa.wrEn1 = 1'b1; ifa.wrAddr1 = 5'd7; ifa.wrData1 = 32'h22;
    ifa.readAddr = {5'd3, 5'd7};
    #1;
    chk("bypass_p1_wins", 64'(ifa.readData[31:0]),  64'h22);
    chk("unwritten_r3",   64'(ifa.readData[63:32]), 64'd0);
    @(negedge clk);
    ifa.wrEn0 = 1'b0; ifa.wrEn1 = 1'b0;
    #1;
    chk("array_p1_wins", 64'(ifa.readData[31:0]), 64'h22);

    // Bypass from port 0 alone
    @(negedge clk);
    ifa.wrEn0 = 1'b1; ifa.wrAddr0 = 5'd3; ifa.wrData0 = 32'h33;
    #1;
    chk("bypass_p0", 64'(ifa.readData[63:32]), 64'h33);

    // Scoreboard: issue R10, clear with load writeback
    @(negedge clk);
    ifa.wrEn0 = 1'b0;
    ifa.issueEn = 1'b1; ifa.issueReg = 5'd10;
    ifa.readAddr = {5'd3, 5'd10};
    #1;
    chk("issue_not_visible", 64'(ifa.readBusy[0]), 64'd0);
    @(negedge clk);
    ifa.issueEn = 1'b0;
    #1;
    chk("r10_busy",     64'(ifa.readBusy[0]), 64'd1);
    chk("count_one",    64'(ifa.busyCount),   64'd1);
    @(negedge clk);
    ifa.wrEn1 = 1'b1; ifa.wrAddr1 = 5'd10; ifa.wrData1 = 32'hABCD;
    #1;
    chk("wb_clears_busy", 64'(ifa.readBusy[0]),     64'd0);
    chk("wb_bypass_data", 64'(ifa.readData[31:0]),  64'hABCD);
    chk("wb_count_held",  64'(ifa.busyCount),       64'd1);
    @(negedge clk);
    ifa.wrEn1 = 1'b0;
    #1;
    chk("count_zero",    64'(ifa.busyCount),      64'd0);
    chk("r10_not_busy",  64'(ifa.readBusy[0]),    64'd0);
    chk("r10_data",      64'(ifa.readData[31:0]), 64'hABCD);

    // Simultaneous set and clear on R4
    @(negedge clk);
    ifa.issueEn = 1'b1; ifa.issueReg = 5'd4;
    ifa.readAddr = {5'd9, 5'd4};
    @(negedge clk);
    ifa.wrEn0 = 1'b1; ifa.wrAddr0 = 5'd4; ifa.wrData0 = 32'h44;
    #1;
    chk("r4_busy_bypassed", 64'(ifa.readBusy[0]), 64'd0);
    @(negedge clk);
    ifa.wrEn0 = 1'b0; ifa.issueEn = 1'b0;
    #1;
    chk("r4_still_busy", 64'(ifa.readBusy[0]),    64'd1);
    chk("r4_new_data",   64'(ifa.readData[31:0]), 64'h44);
    chk("r4_count",      64'(ifa.busyCount),      64'd1);

    // Flush overrides issue of R9
    @(negedge clk);
    ifa.flush = 1'b1;
    ifa.issueEn = 1'b1; ifa.issueReg = 5'd9;
    @(negedge clk);
    ifa.flush = 1'b0; ifa.issueEn = 1'b0;
    #1;
    chk("flush_count", 64'(ifa.busyCount), 64'd0);
    chk("flush_busy",  64'(ifa.readBusy),  64'd0);
    chk("flush_keeps", 64'(ifa.readData[31:0]), 64'h44);

    // Wide build: fill R1..R15, each written and issued in the same cycle
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      ifb.wrEn0 = 1'b1; ifb.wrAddr0 = 4'(i);
      ifb.wrData0 = 64'(i) * 64'h0101_0101_0101_0101;
      ifb.issueEn = 1'b1; ifb.issueReg = 4'(i);
    end
    @(negedge clk);
    ifb.wrEn0 = 1'b0; ifb.issueEn = 1'b0;
    ifb.readAddr = {4'd15, 4'd10, 4'd5, 4'd1};
    #1;
    chk("b_count15",  64'(ifb.busyCount), 64'd15);
    chk("b_busy_all", 64'(ifb.readBusy),  64'hF);
    v = ifb.readData[63:0];
    chk("b_port0_r1",  v, 64'h0101_0101_0101_0101);
    v = ifb.readData[127:64];
    chk("b_port1_r5",  v, 64'h0505_0505_0505_0505);
    v = ifb.readData[191:128];
    chk("b_port2_r10", v, 64'h0A0A_0A0A_0A0A_0A0A);
    v = ifb.readData[255:192];
    chk("b_port3_r15", v, 64'h0F0F_0F0F_0F0F_0F0F);

    // Wide build: port 1 overrides port 0 on a shared address
    @(negedge clk);
    ifb.wrEn0 = 1'b1; ifb.wrAddr0 = 4'd5; ifb.wrData0 = 64'h1;
    ifb.wrEn1 = 1'b1; ifb.wrAddr1 = 4'd5; ifb.wrData1 = 64'hFEDC_BA98_7654_3210;
    @(negedge clk);
    ifb.wrEn0 = 1'b0; ifb.wrEn1 = 1'b0;
    #1;
    v = ifb.readData[127:64];
    chk("b_collision", v, 64'hFEDC_BA98_7654_3210);
    chk("b_count14",   64'(ifb.busyCount), 64'd14);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
